// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode and direction definitions for led_pattern_gen
//
// Purpose: pattern mode encoding and direction constants used by the
//          pattern engine and by anything driving its mode/dir inputs.
// Ports:   none (package).

package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  // Direction / bounce heading: UP moves toward the MSB, DN toward the LSB.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// rtl/led_pattern_gen_tick_prescaler.sv - step-tick prescaler for led_pattern_gen
//
// Purpose: counts 0..CLK_DIV-1 while enabled and flags the last count as a
//          pattern step.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   synchronous active-high reset, clears the count
//   en    in   1 = count, 0 = hold
//   clr   in   synchronous clear (mode change), overrides en
//   step  out  combinational: count is at its last value and en is high

module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  logic [DIV_W-1:0] count;

  assign step = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - four-mode LED pattern generator (fill/chase/bounce/blink)
//
// Purpose: advances a WIDTH-bit LED pattern once every CLK_DIV enabled cycles.
//          Optional build macro LED_PWM_EN adds a 4-bit PWM brightness gate.
// Ports:
//   duty  in   [3:0] PWM on-time in 16ths (only with LED_PWM_EN)
//   clk   in   system clock, rising edge
//   reset in   synchronous active-high reset
//   en    in   1 = run, 0 = pause (prescaler and pattern hold)
//   mode  in   [1:0] 0 FILL, 1 CHASE, 2 BOUNCE, 3 BLINK
//   dir   in   0 = toward MSB, 1 = toward LSB
//   leds  out  [WIDTH-1:0] LED drive
//   tick  out  one-cycle pulse in the cycle leds shows a new step value

module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
`ifdef LED_PWM_EN
  input  logic [3:0]       duty,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  localparam logic [WIDTH-1:0] LSB1 = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB1 = LSB1 << (WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  mode_t            mode_q;
  logic             heading;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_nxt;
  logic             heading_nxt;
  logic [WIDTH-1:0] start_pat;
  logic             is_onehot;
  logic             go_up;
  logic             step;
  logic             mode_chg;

  assign mode_chg = (mode != mode_q);

  tick_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (mode_chg),
    .step  (step)
  );

  assign start_pat = dir ? MSB1 : LSB1;
  assign is_onehot = (pat != '0) && ((pat & (pat - LSB1)) == '0);

  always_comb begin
    pat_nxt     = pat;
    heading_nxt = heading;
    // Bounce moves against its heading only when the bit already sits at the
    // end it is heading for; keeps the engine sane if ever left at an end.
    go_up       = (heading == DIR_UP) ? !pat[WIDTH-1] : pat[0];
    case (mode_q)
      MODE_FILL: begin
        if (pat == '0 || pat == ALL1) begin
          pat_nxt = start_pat;
        end else if (dir) begin
          pat_nxt = (pat >> 1) | MSB1;
        end else begin
          pat_nxt = (pat << 1) | LSB1;
        end
      end
      MODE_CHASE: begin
        if (!is_onehot) begin
          pat_nxt = start_pat;
        end else if (dir) begin
          pat_nxt = {pat[0], pat[WIDTH-1:1]};
        end else begin
          pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
        end
      end
      MODE_BOUNCE: begin
        if (!is_onehot) begin
          pat_nxt     = start_pat;
          heading_nxt = dir;
        end else if (go_up) begin
          pat_nxt     = pat << 1;
          // Flip on the step that lands on the end bit so it shows only once.
          heading_nxt = pat[WIDTH-2] ? DIR_DN : DIR_UP;
        end else begin
          pat_nxt     = pat >> 1;
          heading_nxt = pat[1] ? DIR_UP : DIR_DN;
        end
      end
      MODE_BLINK: begin
        pat_nxt = (pat == '0) ? ALL1 : '0;
      end
      default: begin
        pat_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat     <= '0;
      tick    <= 1'b0;
      mode_q  <= MODE_FILL;
      heading <= DIR_UP;
    end else if (mode_chg) begin
      // Mode change wins over a coincident step: restart cleanly, no tick.
      mode_q  <= mode_t'(mode);
      pat     <= '0;
      tick    <= 1'b0;
      heading <= dir;
    end else begin
      tick <= step;
      if (step) begin
        pat     <= pat_nxt;
        heading <= heading_nxt;
      end
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign leds = pat & {WIDTH{pwm_cnt < duty}};
`else
  assign leds = pat;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen

module tb_led_pattern_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] leds8;
  logic       tick8;
  logic       en4;
  logic [1:0] mode4;
  logic       dir4;
  logic [3:0] leds4;
  logic       tick4;

  int n_cmp = 0;
  int n_bad = 0;

  led_pattern_gen #(.WIDTH(8), .CLK_DIV(4), .DIV_W(3)) dut8 (
`ifdef LED_PWM_EN
    .duty  (4'd0),
`endif
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .dir   (dir),
    .leds  (leds8),
    .tick  (tick8)
  );

  led_pattern_gen #(.WIDTH(4), .CLK_DIV(1), .DIV_W(1)) dut4 (
`ifdef LED_PWM_EN
    .duty  (4'd0),
`endif
    .clk   (clk),
    .reset (reset),
    .en    (en4),
    .mode  (mode4),
    .dir   (dir4),
    .leds  (leds4),
    .tick  (tick4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] mode;
    logic       dir;
    logic       en;
    int         cycles;
    logic [7:0] leds;
    logic       tick;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] m, input logic d, input logic e,
                              input int c, input logic [7:0] l, input logic t);
    vec_t v;
    v.mode = m; v.dir = d; v.en = e; v.cycles = c; v.leds = l; v.tick = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prev;
  logic [3:0] exp_b[9];
  logic [3:0] exp_f[6];

  initial begin
    // Test 1: FILL dir=0, one step per 4 cycles
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h01, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h03, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h07, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h0F, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h1F, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h3F, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h7F, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'hFF, 1'b1));
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 4, 8'h01, 1'b1));
    // Test 5: FILL->CHASE change on the step cycle: clear, no tick, 01 after 4
    tv.push_back(mk(2'd0, 1'b0, 1'b1, 3, 8'h01, 1'b0));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 1, 8'h00, 1'b0));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h01, 1'b1));
    // Test 2: CHASE left, wrap, then reverse
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h02, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h04, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h08, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h10, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h20, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h40, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h80, 1'b1));
    tv.push_back(mk(2'd1, 1'b0, 1'b1, 4, 8'h01, 1'b1));
    tv.push_back(mk(2'd1, 1'b1, 1'b1, 4, 8'h80, 1'b1));
    tv.push_back(mk(2'd1, 1'b1, 1'b1, 4, 8'h40, 1'b1));
    // Test 4: BLINK with a 10-cycle pause in mid-period
    tv.push_back(mk(2'd3, 1'b1, 1'b1, 1, 8'h00, 1'b0));
    tv.push_back(mk(2'd3, 1'b1, 1'b1, 4, 8'hFF, 1'b1));
    tv.push_back(mk(2'd3, 1'b1, 1'b1, 4, 8'h00, 1'b1));
    tv.push_back(mk(2'd3, 1'b1, 1'b1, 2, 8'h00, 1'b0));
    tv.push_back(mk(2'd3, 1'b1, 1'b0, 10, 8'h00, 1'b0));
    tv.push_back(mk(2'd3, 1'b1, 1'b1, 2, 8'hFF, 1'b1));

    exp_b = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    exp_f = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h8};

    reset = 1'b1; en = 1'b1; mode = 2'd0; dir = 1'b0;
    en4 = 1'b0; mode4 = 2'd0; dir4 = 1'b0;
    clk1();
    clk1();
    check("reset_leds8", leds8, 8'h00);
    check("reset_tick8", {7'd0, tick8}, 8'h00);
    check("reset_leds4", {4'd0, leds4}, 8'h00);
    reset = 1'b0;
    prev = 8'h00;

    for (int i = 0; i < tv.size(); i++) begin
      mode = tv[i].mode;
      dir  = tv[i].dir;
      en   = tv[i].en;
      for (int k = 1; k <= tv[i].cycles; k++) begin
        clk1();
        if (k < tv[i].cycles) begin
          check($sformatf("row%0d_hold_leds", i), leds8, prev);
          check($sformatf("row%0d_hold_tick", i), {7'd0, tick8}, 8'h00);
        end else begin
          check($sformatf("row%0d_leds", i), leds8, tv[i].leds);
          check($sformatf("row%0d_tick", i), {7'd0, tick8}, {7'd0, tv[i].tick});
        end
      end
      prev = tv[i].leds;
    end

    // Test 3: BOUNCE on WIDTH=4 with CLK_DIV=1 (step every enabled cycle)
    mode4 = 2'd2; dir4 = 1'b0; en4 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      clk1();
      check($sformatf("bounce%0d_leds", k), {4'd0, leds4}, {4'd0, exp_b[k]});
      check($sformatf("bounce%0d_tick", k), {7'd0, tick4}, (k == 0) ? 8'h00 : 8'h01);
    end

    // FILL toward LSB on WIDTH=4, including the all-ones restart
    mode4 = 2'd0; dir4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk1();
      check($sformatf("filldn%0d_leds", k), {4'd0, leds4}, {4'd0, exp_f[k]});
      check($sformatf("filldn%0d_tick", k), {7'd0, tick4}, (k == 0) ? 8'h00 : 8'h01);
    end
    en4 = 1'b0;

    // Test 6: reset at 3F, on the very cycle a step would fire
    mode = 2'd0; dir = 1'b0; en = 1'b1;
    clk1();
    check("refill_clear", leds8, 8'h00);
    repeat (24) clk1();
    check("refill_3f", leds8, 8'h3F);
    check("refill_3f_tick", {7'd0, tick8}, 8'h01);
    repeat (3) clk1();
    reset = 1'b1;
    clk1();
    check("midreset_leds", leds8, 8'h00);
    check("midreset_tick", {7'd0, tick8}, 8'h00);
    reset = 1'b0;
    repeat (4) clk1();
    check("post_reset_leds", leds8, 8'h01);
    check("post_reset_tick", {7'd0, tick8}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
